// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: mode encoding, edge selection and
// the default fill value shifted out when the transmit buffer is empty.
package spi_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam logic [1:0] SPI_MODE0 = 2'd0;
    localparam logic [1:0] SPI_MODE1 = 2'd1;
    localparam logic [1:0] SPI_MODE2 = 2'd2;
    localparam logic [1:0] SPI_MODE3 = 2'd3;

    // Every bit of the default underrun word takes this value.
    localparam logic UNDERRUN_FILL = 1'b1;

    // Modes 0 and 3 sample on the rising SCK edge; modes 1 and 2 on the falling one.
    function automatic logic sample_on_rise(input spi_mode_t mode);
        return ~(mode.cpol ^ mode.cpha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus a third flop that
// turns level changes into single-cycle rise/fall strobes.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronise the pin and keep one cycle of history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            prev_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;
    assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave, DATA_W bits per word, MSB first, mode selectable per frame.
// All pins are oversampled in the clk domain; MISO is driven from a shift
// register that reloads from a one-word holding buffer at word boundaries.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                CNT_W        = 8,
    parameter logic [DATA_W-1:0] UNDERRUN_VAL = {DATA_W{UNDERRUN_FILL}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              ssel,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_abort,
    output logic              tx_underrun,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy
);

    localparam int                BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    // Synchronised pin events
    logic sck_rise_s;
    logic sck_fall_s;
    logic ssel_rise_s;
    logic ssel_fall_s;
    logic mosi_meta_r;
    logic mosi_sync_r;

    // Frame / receive state
    spi_mode_t         mode_r;
    logic              busy_r;
    logic              miso_oe_r;
    logic [BIT_W-1:0]  bitcnt_r;
    logic [DATA_W-1:0] rx_shift_r;
    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r;
    logic              rx_abort_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic              shift_pending_r;
    logic              load_pending_r;

    // Transmit state
    logic [DATA_W-1:0] tx_shift_r;
    logic [DATA_W-1:0] hold_r;
    logic              hold_full_r;
    logic              tx_ready_r;
    logic              tx_underrun_r;

    // Decoded per-cycle actions
    logic              sample_rise_s;
    logic              sample_ev_s;
    logic              shift_ev_s;
    logic              load_s;
    logic              shift_s;
    logic              accept_s;
    logic              hold_next_s;
    logic [DATA_W-1:0] rx_new_s;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sck),
        .rise  (sck_rise_s),
        .fall  (sck_fall_s)
    );

    // Chip select idles high so a held-low ssel reads as a fresh frame after reset.
    spi_sync_edge #(.RST_VAL(1'b1)) u_ssel_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ssel),
        .rise  (ssel_rise_s),
        .fall  (ssel_fall_s)
    );

    // Two-flop synchroniser for MOSI; aligned in depth with the SCK edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    assign rx_new_s = {rx_shift_r[DATA_W-2:0], mosi_sync_r};

    // Decode SCK strobes into sample/shift events and the transmit actions they imply.
    always_comb begin
        sample_rise_s = sample_on_rise(mode_r);
        sample_ev_s   = 1'b0;
        shift_ev_s    = 1'b0;
        if (busy_r && !ssel_fall_s && !ssel_rise_s) begin
            if (sample_rise_s) begin
                sample_ev_s = sck_rise_s;
                shift_ev_s  = sck_fall_s;
            end else begin
                sample_ev_s = sck_fall_s;
                shift_ev_s  = sck_rise_s;
            end
        end else begin
            sample_ev_s = 1'b0;
            shift_ev_s  = 1'b0;
        end
        load_s      = ssel_fall_s | (shift_ev_s & load_pending_r);
        shift_s     = shift_ev_s & ~load_pending_r & shift_pending_r;
        accept_s    = tx_valid & tx_ready_r;
        hold_next_s = (hold_full_r & ~load_s) | accept_s;
    end

    // Frame control and receive path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r          <= '{cpol: 1'b0, cpha: 1'b0};
            busy_r          <= 1'b0;
            miso_oe_r       <= 1'b0;
            bitcnt_r        <= '0;
            rx_shift_r      <= '0;
            rx_data_r       <= '0;
            rx_valid_r      <= 1'b0;
            rx_abort_r      <= 1'b0;
            word_cnt_r      <= '0;
            shift_pending_r <= 1'b0;
            load_pending_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_abort_r <= 1'b0;
            if (ssel_fall_s) begin
                mode_r          <= '{cpol: cpol, cpha: cpha};
                busy_r          <= 1'b1;
                miso_oe_r       <= 1'b1;
                bitcnt_r        <= '0;
                rx_shift_r      <= '0;
                word_cnt_r      <= '0;
                shift_pending_r <= 1'b0;
                load_pending_r  <= 1'b0;
            end else if (ssel_rise_s) begin
                busy_r          <= 1'b0;
                miso_oe_r       <= 1'b0;
                bitcnt_r        <= '0;
                shift_pending_r <= 1'b0;
                load_pending_r  <= 1'b0;
                // A partially shifted word is dropped, only flagged.
                rx_abort_r      <= (bitcnt_r != '0);
            end else if (sample_ev_s) begin
                rx_shift_r      <= rx_new_s;
                shift_pending_r <= 1'b1;
                if (bitcnt_r == LAST_BIT) begin
                    bitcnt_r       <= '0;
                    rx_data_r      <= rx_new_s;
                    rx_valid_r     <= 1'b1;
                    load_pending_r <= 1'b1;
                    if (word_cnt_r != CNT_MAX) begin
                        word_cnt_r <= word_cnt_r + CNT_W'(1);
                    end
                end else begin
                    bitcnt_r <= bitcnt_r + BIT_W'(1);
                end
            end else if (shift_ev_s) begin
                if (load_pending_r) begin
                    load_pending_r  <= 1'b0;
                    shift_pending_r <= 1'b0;
                end else begin
                    shift_pending_r <= 1'b0;
                end
            end
        end
    end

    // Transmit shift register and one-word holding buffer with valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_r    <= '0;
            hold_r        <= '0;
            hold_full_r   <= 1'b0;
            tx_ready_r    <= 1'b1;
            tx_underrun_r <= 1'b0;
        end else begin
            tx_underrun_r <= 1'b0;
            if (load_s) begin
                if (hold_full_r) begin
                    tx_shift_r <= hold_r;
                end else begin
                    tx_shift_r    <= UNDERRUN_VAL;
                    tx_underrun_r <= 1'b1;
                end
            end else if (shift_s) begin
                tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
            end
            // A load in the same cycle as an accept takes the old buffer word.
            if (accept_s) begin
                hold_r <= tx_data;
            end
            hold_full_r <= hold_next_s;
            tx_ready_r  <= ~hold_next_s;
        end
    end

    assign miso        = busy_r & tx_shift_r[DATA_W-1];
    assign miso_oe     = miso_oe_r;
    assign busy        = busy_r;
    assign tx_ready    = tx_ready_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign rx_abort    = rx_abort_r;
    assign tx_underrun = tx_underrun_r;
    assign word_cnt    = word_cnt_r;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param (DATA_W=8): the bench plays the SPI
// master on the pins and the transmit client on the parallel side.
module tb_spi_slave_param;
    import spi_pkg::*;

    localparam int HALF = 80;

    logic       clk;
    logic       rst_n;
    logic       sck;
    logic       ssel;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       cpol;
    logic       cpha;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_abort;
    logic       tx_underrun;
    logic [7:0] word_cnt;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    int         rxv_cnt = 0;
    int         abort_cnt = 0;
    int         ur_cnt = 0;
    logic [7:0] rx_q[$];

    logic [7:0] g1, g2, g3;
    int         b_rxv, b_ab, b_ur, b_q;

    spi_slave_param dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sck         (sck),
        .ssel        (ssel),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .cpol        (cpol),
        .cpha        (cpha),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_abort    (rx_abort),
        .tx_underrun (tx_underrun),
        .word_cnt    (word_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count the one-cycle strobes and record every received word.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rxv_cnt = rxv_cnt + 1;
            rx_q.push_back(rx_data);
        end
        if (rx_abort === 1'b1) abort_cnt = abort_cnt + 1;
        if (tx_underrun === 1'b1) ur_cnt = ur_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rx_at(input int idx);
        if (rx_q.size() > idx) return rx_q[idx];
        else return 8'hxx;
    endfunction

    task automatic snap();
        b_rxv = rxv_cnt;
        b_ab  = abort_cnt;
        b_ur  = ur_cnt;
        b_q   = rx_q.size();
    endtask

    // Offer one word; tx_valid stays high afterwards when keep is set.
    task automatic tx_write(input logic [7:0] d, input logic keep);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        @(posedge clk); #2;
        if (!keep) tx_valid = 1'b0;
        chk("tx_accept_wait", 32'(n < 1000), 32'd1);
    endtask

    task automatic frame_begin(input logic pol, input logic pha);
        cpol = pol;
        cpha = pha;
        sck  = pol;
        #(HALF);
        ssel = 1'b0;
        #(HALF);
    endtask

    task automatic frame_end();
        #(HALF);
        ssel = 1'b1;
        #(HALF);
    endtask

    // Master side of nbits SCK cycles; miso is captured on the sample edge.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (cpha == 1'b0) begin
                mosi = mo[7-i];
                #(HALF);
                sck = ~sck;
                mi = {mi[6:0], miso};
                #(HALF);
                sck = ~sck;
            end else begin
                sck = ~sck;
                mosi = mo[7-i];
                #(HALF);
                sck = ~sck;
                mi = {mi[6:0], miso};
                #(HALF);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        sck      = 1'b0;
        ssel     = 1'b1;
        mosi     = 1'b0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        #37;

        // Reset state
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_pulses", {29'd0, rx_valid, rx_abort, tx_underrun}, 32'd0);
        rst_n = 1'b1;
        #50;

        // 1: mode 0, single word
        snap();
        tx_write(8'hA5, 1'b0);
        chk("t1_ready_low", 32'(tx_ready), 32'd0);
        frame_begin(SPI_MODE0[1], SPI_MODE0[0]);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_miso_oe", 32'(miso_oe), 32'd1);
        chk("t1_ready_after_load", 32'(tx_ready), 32'd1);
        spi_xfer(8'h3C, 8, g1);
        frame_end();
        chk("t1_miso_word", 32'(g1), 32'hA5);
        chk("t1_rx_data", 32'(rx_data), 32'h3C);
        chk("t1_rx_valid_cnt", 32'(rxv_cnt - b_rxv), 32'd1);
        chk("t1_word_cnt", 32'(word_cnt), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_underrun_tail", 32'(ur_cnt - b_ur), 32'd1);

        // 2: modes 1..3, two-word frames
        for (int m = 1; m < 4; m++) begin
            logic [1:0] md;
            md = 2'(m);
            snap();
            tx_write(8'h81, 1'b0);
            frame_begin(md[1], md[0]);
            fork
                spi_xfer(8'h55, 8, g1);
                tx_write(8'h7E, 1'b0);
            join
            spi_xfer(8'hAA, 8, g2);
            frame_end();
            chk("t2_miso_w0", 32'(g1), 32'h81);
            chk("t2_miso_w1", 32'(g2), 32'h7E);
            chk("t2_rx_valid_cnt", 32'(rxv_cnt - b_rxv), 32'd2);
            chk("t2_rx_w0", 32'(rx_at(b_q)), 32'h55);
            chk("t2_rx_w1", 32'(rx_at(b_q + 1)), 32'hAA);
            chk("t2_word_cnt", 32'(word_cnt), 32'd2);
            chk("t2_underrun", 32'(ur_cnt - b_ur), (md[0] ? 32'd0 : 32'd1));
        end

        // 3: empty buffer at frame start (mode 1, so no tail reload)
        snap();
        frame_begin(SPI_MODE1[1], SPI_MODE1[0]);
        chk("t3_underrun_start", 32'(ur_cnt - b_ur), 32'd1);
        spi_xfer(8'h00, 8, g1);
        frame_end();
        chk("t3_miso_word", 32'(g1), 32'hFF);
        chk("t3_underrun_total", 32'(ur_cnt - b_ur), 32'd1);
        chk("t3_rx_data", 32'(rx_data), 32'h00);

        // 4: frame ends after 5 bits
        snap();
        frame_begin(SPI_MODE0[1], SPI_MODE0[0]);
        spi_xfer(8'hE7, 5, g1);
        #(HALF);
        ssel = 1'b1;
        #30;
        chk("t4_busy_3clk", 32'(busy), 32'd0);
        #(HALF);
        chk("t4_abort_cnt", 32'(abort_cnt - b_ab), 32'd1);
        chk("t4_no_rx_valid", 32'(rxv_cnt - b_rxv), 32'd0);
        chk("t4_word_cnt", 32'(word_cnt), 32'd0);
        chk("t4_miso_oe", 32'(miso_oe), 32'd0);

        // 5: tx_valid held across word-boundary loads
        snap();
        fork
            begin
                tx_write(8'h01, 1'b1);
                tx_write(8'h02, 1'b1);
                tx_write(8'h03, 1'b0);
            end
            begin
                #200;
                frame_begin(SPI_MODE0[1], SPI_MODE0[0]);
                spi_xfer(8'h11, 8, g1);
                spi_xfer(8'h22, 8, g2);
                spi_xfer(8'h33, 8, g3);
                frame_end();
            end
        join
        chk("t5_miso_w0", 32'(g1), 32'h01);
        chk("t5_miso_w1", 32'(g2), 32'h02);
        chk("t5_miso_w2", 32'(g3), 32'h03);
        chk("t5_word_cnt", 32'(word_cnt), 32'd3);
        chk("t5_rx_last", 32'(rx_data), 32'h33);

        // 6: reset mid-word with ssel held low, then a fresh frame
        frame_begin(SPI_MODE0[1], SPI_MODE0[0]);
        spi_xfer(8'hF0, 3, g1);
        rst_n = 1'b0;
        #10;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("t6_rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("t6_rst_rx_data", 32'(rx_data), 32'h00);
        chk("t6_rst_word_cnt", 32'(word_cnt), 32'd0);
        #30;
        rst_n = 1'b1;
        snap();
        #100;
        chk("t6_restart_busy", 32'(busy), 32'd1);
        spi_xfer(8'h96, 8, g1);
        frame_end();
        chk("t6_miso_word", 32'(g1), 32'hFF);
        chk("t6_rx_data", 32'(rx_data), 32'h96);
        chk("t6_word_cnt", 32'(word_cnt), 32'd1);
        chk("t6_rx_valid_cnt", 32'(rxv_cnt - b_rxv), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
